// File: rtl/spu_regfile_dp.sv
// spu_regfile_dp: dual-issue SPU register file with even/odd write-back bypass,
// pending-register scoreboard and a reset-initiated clear sequencer.
module spu_regfile_dp #(
   parameter int RFWIDTH = 128,
   parameter int NREGS   = 128,
   parameter int REGBITS = 7,
   parameter int ZERO_R0 = 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               busy,
   input  logic [REGBITS-1:0] ra_e,
   input  logic [REGBITS-1:0] rb_e,
   input  logic [REGBITS-1:0] rc_e,
   input  logic [REGBITS-1:0] ra_o,
   input  logic [REGBITS-1:0] rb_o,
   input  logic [REGBITS-1:0] rc_o,
   input  logic [2:0]         src_vld_e,
   input  logic [2:0]         src_vld_o,
   output logic [RFWIDTH-1:0] rda_e,
   output logic [RFWIDTH-1:0] rdb_e,
   output logic [RFWIDTH-1:0] rdc_e,
   output logic [RFWIDTH-1:0] rda_o,
   output logic [RFWIDTH-1:0] rdb_o,
   output logic [RFWIDTH-1:0] rdc_o,
   input  logic               iss_e,
   input  logic               iss_o,
   input  logic [REGBITS-1:0] rt_e,
   input  logic [REGBITS-1:0] rt_o,
   output logic               stall_e,
   output logic               stall_o,
   input  logic               we_e,
   input  logic               we_o,
   input  logic [REGBITS-1:0] wa_e,
   input  logic [REGBITS-1:0] wa_o,
   input  logic [RFWIDTH-1:0] wd_e,
   input  logic [RFWIDTH-1:0] wd_o
);
   typedef enum logic {CLEAR, RUN} state_t;
   state_t             state;
   logic [REGBITS-1:0] cnt;
   logic [RFWIDTH-1:0] mem [NREGS];
   logic [NREGS-1:0]   pending, pending_nxt;

   assign busy = reset || state == CLEAR;

   function automatic logic is_z(input logic [REGBITS-1:0] a);
      return ZERO_R0 != 0 && a == '0;
   endfunction

   function automatic logic wb_hit(input logic [REGBITS-1:0] a);
      return (we_o && wa_o == a) || (we_e && wa_e == a);
   endfunction

   // odd port has priority, matching the write order below
   function automatic logic [RFWIDTH-1:0] rd(input logic [REGBITS-1:0] a);
      return (busy || is_z(a)) ? '0 : (we_o && wa_o == a) ? wd_o : (we_e && wa_e == a) ? wd_e : mem[a];
   endfunction

   function automatic logic hz(input logic [REGBITS-1:0] a, input logic v);
      return v && pending[a] && !wb_hit(a);
   endfunction

   function automatic logic raw(input logic [REGBITS-1:0] a, input logic v);
      return v && iss_e && a == rt_e && !is_z(a);
   endfunction

   assign rda_e = rd(ra_e);
   assign rdb_e = rd(rb_e);
   assign rdc_e = rd(rc_e);
   assign rda_o = rd(ra_o);
   assign rdb_o = rd(rb_o);
   assign rdc_o = rd(rc_o);

   assign stall_e = busy || hz(ra_e, src_vld_e[0]) || hz(rb_e, src_vld_e[1]) || hz(rc_e, src_vld_e[2]);
   assign stall_o = busy || hz(ra_o, src_vld_o[0]) || hz(rb_o, src_vld_o[1]) || hz(rc_o, src_vld_o[2])
                  || raw(ra_o, src_vld_o[0]) || raw(rb_o, src_vld_o[1]) || raw(rc_o, src_vld_o[2]);

   // clears first so a same-cycle issue wins
   always_comb begin
      pending_nxt = pending;
      if (we_e) pending_nxt[wa_e] = 1'b0;
      if (we_o) pending_nxt[wa_o] = 1'b0;
      if (iss_e) pending_nxt[rt_e] = 1'b1;
      if (iss_o) pending_nxt[rt_o] = 1'b1;
      if (ZERO_R0 != 0) pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         cnt     <= '0;
         pending <= '0;
      end else if (state == CLEAR) begin
         mem[cnt] <= '0;
         cnt      <= cnt + REGBITS'(1);
         if (cnt == REGBITS'(NREGS - 1)) state <= RUN;
      end else begin
         if (we_e && !is_z(wa_e)) mem[wa_e] <= wd_e;
         if (we_o && !is_z(wa_o)) mem[wa_o] <= wd_o;
         pending <= pending_nxt;
      end
   end
endmodule

// File: doc/spu_regfile_dp.md
# spu_regfile_dp

Parametrised dual-issue register file for the Cell SPU core, replacing the single-cycle-hack register file. It has explicit even/odd write-back ports with same-cycle write-to-read bypass, three read ports per issue slot, a per-register pending scoreboard that raises stall to the issue stage, and a reset-initiated clear sequencer that zeroes every entry. It sits between decode/issue and the even/odd execution pipes.

## Interface
- RFWIDTH, 128, register width in bits
- NREGS, 128, number of registers (power of two)
- REGBITS, 7, address width, log2(NREGS)
- ZERO_R0, 1, when 1 register 0 reads as 0 and ignores writes
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- busy  out  1  clear sequence in progress
- ra_e, rb_e, rc_e  in  REGBITS  even-slot source addresses
- ra_o, rb_o, rc_o  in  REGBITS  odd-slot source addresses
- src_vld_e, src_vld_o  in  3  source-valid mask per slot, bits {rc,rb,ra}
- rda_e, rdb_e, rdc_e, rda_o, rdb_o, rdc_o  out  RFWIDTH  read data, combinational
- iss_e, iss_o  in  1  instruction issued in slot this cycle
- rt_e, rt_o  in  REGBITS  issued instruction's destination
- stall_e, stall_o  out  1  source hazard in slot, combinational
- we_e, we_o  in  1  write-back valid from even/odd pipe
- wa_e, wa_o  in  REGBITS  write-back address
- wd_e, wd_o  in  RFWIDTH  write-back data

## Operation
- FSM states: CLEAR and RUN. Reset forces CLEAR with clear counter = 0. CLEAR writes 0 to entry[counter] each cycle, then increments. When counter = NREGS-1 the FSM writes that entry and goes to RUN.
- busy = 1 in CLEAR, and also while reset is high. Writes and issues are ignored in CLEAR. Reads return 0. stall_e = stall_o = 1.
- Reset asserted mid-clear restarts the counter at 0. Reset in RUN clears all pending bits and re-enters CLEAR.
- Write, in RUN: if we_x is set, entry[wa_x] <= wd_x. If both ports write the same address, the odd port wins. With ZERO_R0 = 1, writes to address 0 are dropped.
- Read: rdX = 0 if ZERO_R0 and address = 0. Otherwise, if we_o and wa_o == address, return wd_o. Otherwise, if we_e and wa_e == address, return wd_e. Otherwise, return the stored entry. Bypass priority matches write priority.
- Scoreboard: NREGS pending bits.
  - iss_x sets pending[rt_x]. A write-back on we_x clears pending[wa_x].
  - Set and clear of the same register in the same cycle: set wins.
  - Register 0 is never pending when ZERO_R0 = 1.
- stall_e = 1 for any valid even source s where pending[s] is set and s is not being written back this cycle. A bypassed source does not stall.
- stall_o uses the same rule for odd sources. It is additionally set if iss_e is high and any valid odd source equals rt_e (intra-pair RAW). Odd issues after even in program order.
- The issue stage must not assert iss_x while stall_x = 1. The block does not guard against this.

## Timing
- Read latency is 0 cycles (combinational). Write commits at the rising edge; the stored value is visible from the next cycle. Same-cycle visibility is via bypass.
- Pending bit sets at the edge after iss_x and clears at the edge of the write-back cycle. stall drops in the write-back cycle itself, via bypass.
- Clear duration: busy stays high for exactly NREGS cycles after the first cycle with reset low, then falls.
- Reset values: busy = 1, stall_e = stall_o = 1, all read outputs = 0, all pending bits = 0, all entries = 0 once CLEAR completes.

## Test plan
- Reset 1 cycle, then release. Expect busy high for 128 cycles and low on cycle 129. Read of r5 returns 0. Write to r5 during busy is ignored.
- Write r10 = 0x…DEAD via the even port. In the same cycle, ra_e = 10 reads 0x…DEAD (bypass). On the next cycle, rda_o with ra_o = 10 reads the stored value.
- Same cycle: we_e to r20 = 1 and we_o to r20 = 2. Read of r20 returns 2, both in that cycle and afterwards.
- Issue even with rt_e = 7. Next cycle, ra_o = 7 with src_vld_o = 001 gives stall_o = 1. A write-back of r7 on we_o drops stall_o in that same cycle, and rda_o equals wd_o.
- Same cycle: iss_e with rt_e = 3, and odd with rb_o = 3, src_vld_o = 010. Expect stall_o = 1 and stall_e = 0.
- With ZERO_R0 = 1: write r0 = 0xFF, then read r0. Expect 0. Issue with rt = 0 never stalls a consumer.
- Reset at clear cycle 60. Expect busy to persist for 128 full cycles after release.
